// File: rtl/led_sig_ctrl.sv
// LED sequencer: synchronises and debounces ext_sig, then drives a polarity-corrected LED in
// FOLLOW / TOGGLE / BLINK / OFF modes. Define LED_SIG_CTRL_DIM_EN to add PWM dimming (PWM_DUTY/16).
module led_sig_ctrl #(
    parameter bit          LED_ACTIVE_LOW    = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES   = 250000,
    parameter int unsigned BLINK_HALF_PERIOD = 6250000
`ifdef LED_SIG_CTRL_DIM_EN
    ,
    parameter logic [3:0]  PWM_DUTY          = 4'd4
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ext_sig,
    input  logic [1:0] mode,
    output logic       led,
    output logic       sync_out,
    output logic       edge_pulse
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned BL_W = $clog2(BLINK_HALF_PERIOD + 1);

    localparam logic [1:0] M_FOLLOW = 2'd0;
    localparam logic [1:0] M_TOGGLE = 2'd1;
    localparam logic [1:0] M_BLINK  = 2'd2;
    localparam logic [1:0] M_OFF    = 2'd3;

    logic            s1_q, s2_q;
    logic            stable_q, stable_d;
    logic            prev_q;
    logic            edge_q, edge_d;
    logic            tog_q, tog_d;
    logic            phase_q, phase_d;
    logic            led_q, led_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
    logic [1:0]      mode_q, mode_d;
    logic            entry_c, lvl_c, eff_c;

`ifdef LED_SIG_CTRL_DIM_EN
    logic [3:0]      pwm_q, pwm_d;
`endif

    // Next-state and LED level decode
    always_comb begin
        mode_d   = mode;
        entry_c  = (mode_d != mode_q);
        stable_d = stable_q;
        db_cnt_d = '0;
        tog_d    = tog_q;
        bl_cnt_d = bl_cnt_q;
        phase_d  = phase_q;
        lvl_c    = 1'b0;

        // Level must differ for DEBOUNCE_CYCLES consecutive cycles before it is accepted
        if (s2_q != stable_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = s2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        edge_d = stable_q & ~prev_q;

        case (mode_q)
            M_FOLLOW: lvl_c = stable_q;
            M_TOGGLE: begin
                lvl_c = tog_q;
                if (edge_q) begin
                    tog_d = ~tog_q;
                end
            end
            M_BLINK: begin
                lvl_c = stable_q & phase_q;
                if (!stable_q) begin
                    bl_cnt_d = '0;
                    phase_d  = 1'b1;
                end else if (bl_cnt_q == BL_W'(BLINK_HALF_PERIOD - 1)) begin
                    bl_cnt_d = '0;
                    phase_d  = ~phase_q;
                end else begin
                    bl_cnt_d = bl_cnt_q + BL_W'(1);
                end
            end
            M_OFF:    lvl_c = 1'b0;
            default:  lvl_c = 1'b0;
        endcase

        // Entry happens on the same edge mode_q takes the new value, so it overrides any update above
        if (entry_c && (mode_d == M_TOGGLE)) begin
            tog_d = 1'b0;
        end
        if (entry_c && (mode_d == M_BLINK)) begin
            bl_cnt_d = '0;
            phase_d  = 1'b1;
        end

`ifdef LED_SIG_CTRL_DIM_EN
        pwm_d = pwm_q + 4'd1;
        eff_c = lvl_c & (pwm_q < PWM_DUTY);
`else
        eff_c = lvl_c;
`endif
        led_d = eff_c ^ LED_ACTIVE_LOW;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            edge_q   <= 1'b0;
            db_cnt_q <= '0;
            tog_q    <= 1'b0;
            bl_cnt_q <= '0;
            phase_q  <= 1'b0;
            mode_q   <= M_FOLLOW;
            led_q    <= LED_ACTIVE_LOW;
`ifdef LED_SIG_CTRL_DIM_EN
            pwm_q    <= 4'd0;
`endif
        end else begin
            s1_q     <= ext_sig;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            edge_q   <= edge_d;
            db_cnt_q <= db_cnt_d;
            tog_q    <= tog_d;
            bl_cnt_q <= bl_cnt_d;
            phase_q  <= phase_d;
            mode_q   <= mode_d;
            led_q    <= led_d;
`ifdef LED_SIG_CTRL_DIM_EN
            pwm_q    <= pwm_d;
`endif
        end
    end

    assign led        = led_q;
    assign sync_out   = stable_q;
    assign edge_pulse = edge_q;

endmodule
